lru_nway_repl: RTL

//  Parametrised true-LRU replacement controller for an N-way set-associative cache.

---
 rtl/lru_nway_repl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lru_nway_repl.sv
// True-LRU replacement controller: per-set age permutations (0=MRU .. WAYS-1=LRU),
// touch/demote updates from the hit/fill path and a registered victim for the miss path.
module lru_nway_repl #(
    parameter int  WAYS  = 4,
    parameter int  SETS  = 64,
    localparam int IDX_W = $clog2(SETS),
    localparam int AGE_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             ready,
    input  logic             op_valid,
    input  logic             op_demote,
    input  logic [IDX_W-1:0] op_idx,
    input  logic [AGE_W-1:0] op_way,
    input  logic             query_valid,
    input  logic [IDX_W-1:0] query_idx,
    input  logic [WAYS-1:0]  valid_mask,
    input  logic [WAYS-1:0]  lock_mask,
    output logic             victim_valid,
    output logic [AGE_W-1:0] victim_way,
    output logic             victim_none
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);
    localparam logic [AGE_W-1:0] LRU_AGE  = AGE_W'(WAYS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

    // One row per set holds the age of every way; no reset, the init sweep fills it.
    logic [WAYS-1:0][AGE_W-1:0] age_q [SETS];

    logic [WAYS-1:0][AGE_W-1:0] op_row;
    logic [WAYS-1:0][AGE_W-1:0] upd_row;
    logic [WAYS-1:0][AGE_W-1:0] init_row;
    logic [WAYS-1:0][AGE_W-1:0] q_row;
    logic [AGE_W-1:0]           op_age;

    logic             victim_valid_q, victim_valid_d;
    logic [AGE_W-1:0] victim_way_q, victim_way_d;
    logic             victim_none_q, victim_none_d;

    logic             free_found;
    logic [AGE_W-1:0] free_way;
    logic             old_found;
    logic [AGE_W-1:0] old_way;
    logic [AGE_W-1:0] old_age;

    // ------------------------------------------------------------------
    // Init-sweep / run FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_SET) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    assign ready = (state_q == ST_RUN);

    // ------------------------------------------------------------------
    // Age update: every way compares its own age against the target's age
    // ------------------------------------------------------------------
    assign op_row = age_q[op_idx];
    assign op_age = op_row[op_way];
    assign q_row  = age_q[query_idx];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign init_row[gi] = AGE_W'(gi);
            assign upd_row[gi]  =
                (op_way == AGE_W'(gi)) ? (op_demote ? LRU_AGE : '0) :
                (op_demote && (op_row[gi] > op_age))  ? op_row[gi] - AGE_W'(1) :
                (!op_demote && (op_row[gi] < op_age)) ? op_row[gi] + AGE_W'(1) :
                op_row[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == ST_INIT) begin
                age_q[init_cnt_q] <= init_row;
            end else if (op_valid) begin
                age_q[op_idx] <= upd_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Victim selection from the pre-update ages (no same-edge bypass)
    // ------------------------------------------------------------------
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_mask[w] && !lock_mask[w]) begin
                free_found = 1'b1;
                free_way   = AGE_W'(w);
            end
        end
        old_found = 1'b0;
        old_way   = '0;
        old_age   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!lock_mask[w] && (!old_found || (q_row[w] > old_age))) begin
                old_found = 1'b1;
                old_way   = AGE_W'(w);
                old_age   = q_row[w];
            end
        end
        victim_valid_d = query_valid && ready;
        victim_way_d   = victim_way_q;
        victim_none_d  = victim_none_q;
        if (victim_valid_d) begin
            victim_none_d = !old_found;
            victim_way_d  = free_found ? free_way : (old_found ? old_way : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            victim_valid_q <= 1'b0;
            victim_way_q   <= '0;
            victim_none_q  <= 1'b0;
        end else begin
            victim_valid_q <= victim_valid_d;
            victim_way_q   <= victim_way_d;
            victim_none_q  <= victim_none_d;
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign victim_none  = victim_none_q;

endmodule
